// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the CPU fetch path: reset/halt constants, the
// PC sequencer state encoding and the branch-offset helper.
package mips_cpu_pkg;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DELAY = 2'd1,
    HALT  = 2'd2
  } pc_state_t;

  // Branch offset: sign-extend the 16-bit immediate and scale to bytes.
  function automatic logic [31:0] sext_shift(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_cpu_pc_target.sv
// Combinational redirect detection and target selection.
// Priority: register jump, then absolute jump, then taken branch.
module mips_cpu_pc_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] instr,
  input  logic [31:0] reg_target,
  input  logic        branch,
  input  logic        branch_cond,
  input  logic        jump,
  input  logic        jump1,
  output logic        redirect,
  output logic [31:0] target
);

  // Opcode bits are the decoder's business; only the index/immediate is used here.
  logic unused_op;
  assign unused_op = ^instr[31:26];

  // Pick the redirect target by priority.
  always_comb begin
    redirect = 1'b0;
    target   = pc4;
    if (jump1) begin
      redirect = 1'b1;
      target   = reg_target;
    end else if (jump) begin
      redirect = 1'b1;
      target   = {pc4[31:28], instr[25:0], 2'b00};
    end else if (branch && branch_cond) begin
      redirect = 1'b1;
      target   = pc4 + sext_shift(instr[15:0]);
    end
  end

endmodule

// File: rtl/mips_cpu_pc_fetch.sv
// Program counter and fetch sequencer with a single branch delay slot.
// A taken redirect latches its target, the next sequential instruction
// (delay slot) executes, then the PC moves to the latched target. A
// committed target of HALT_ADDR, or a misaligned register target, halts
// the sequencer until reset.
module mips_cpu_pc_fetch
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] instr,
  input  logic        branch,
  input  logic        branch_cond,
  input  logic        jump,
  input  logic        jump1,
  input  logic [31:0] reg_target,
  output logic [31:0] link_addr,
  output logic        active,
  output logic        addr_error
);

  pc_state_t   state;
  logic [31:0] pc;
  logic [31:0] pending;
  logic [31:0] pc4;
  logic [31:0] pc8;
  logic        redirect;
  logic [31:0] target;
  logic        misaligned;

  assign pc4           = pc + 32'd4;
  assign pc8           = pc + 32'd8;
  assign instr_address = pc;
  assign instr         = instr_readdata;
  assign link_addr     = pc8;
  assign misaligned    = jump1 && (reg_target[1:0] != 2'b00);

  mips_cpu_pc_target u_target (
    .pc4         (pc4),
    .instr       (instr_readdata),
    .reg_target  (reg_target),
    .branch      (branch),
    .branch_cond (branch_cond),
    .jump        (jump),
    .jump1       (jump1),
    .redirect    (redirect),
    .target      (target)
  );

  // PC / delay-slot state machine; stall freezes every register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RUN;
      pc         <= RESET_VECTOR;
      pending    <= 32'h0;
      active     <= 1'b1;
      addr_error <= 1'b0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          pc <= pc4;
          if (redirect) begin
            state <= DELAY;
            if (misaligned) begin
              // Bad register target: finish the delay slot, then halt.
              addr_error <= 1'b1;
              pending    <= HALT_ADDR;
            end else begin
              pending <= target;
            end
          end
        end
        DELAY: begin
          // Redirects in the delay slot are ignored.
          pc <= pending;
          if (pending == HALT_ADDR) begin
            state  <= HALT;
            active <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        HALT: begin
          pc     <= HALT_ADDR;
          active <= 1'b0;
        end
        default: begin
          state  <= HALT;
          pc     <= HALT_ADDR;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_pc_fetch.sv
// Directed bench for the PC/fetch sequencer: a vector table stepped one
// clock per row, plus hand-written halt and pass-through sequences.
module tb_mips_cpu_pc_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] instr;
  logic        branch;
  logic        branch_cond;
  logic        jump;
  logic        jump1;
  logic [31:0] reg_target;
  logic [31:0] link_addr;
  logic        active;
  logic        addr_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_cpu_pc_fetch dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .instr          (instr),
    .branch         (branch),
    .branch_cond    (branch_cond),
    .jump           (jump),
    .jump1          (jump1),
    .reg_target     (reg_target),
    .link_addr      (link_addr),
    .active         (active),
    .addr_error     (addr_error)
  );

  typedef struct {
    logic        rst_n;
    logic        stl;
    logic        br;
    logic        cond;
    logic        jmp;
    logic        jmp1;
    logic [31:0] iw;
    logic [31:0] rt;
    logic [31:0] exp_pc;
    logic        exp_act;
    logic        exp_err;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  // Instruction words
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] BEQ3   = 32'h1000_0003; // beq, imm = +3
  localparam logic [31:0] J_100  = 32'h0BF0_0040; // j BFC00100 (from BFCxxxxx)
  localparam logic [31:0] J_200  = 32'h0BF0_0080; // j BFC00200

  function automatic vec_t mk(logic r, logic s, logic b, logic c, logic j,
                              logic j1, logic [31:0] iw, logic [31:0] rt,
                              logic [31:0] pc, logic a, logic e);
    vec_t v;
    v.rst_n = r; v.stl = s; v.br = b; v.cond = c; v.jmp = j; v.jmp1 = j1;
    v.iw = iw; v.rt = rt; v.exp_pc = pc; v.exp_act = a; v.exp_err = e;
    return v;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_n        = v.rst_n;
    stall          = v.stl;
    branch         = v.br;
    branch_cond    = v.cond;
    jump           = v.jmp;
    jump1          = v.jmp1;
    instr_readdata = v.iw;
    reg_target     = v.rt;
  endtask

  initial begin
    //                r  s  b  c  j  j1 iw     rt            exp_pc        act err
    // reset, free run
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00000, 1, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00004, 1, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00008, 1, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC0000C, 1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00010, 1, 0);
    // BEQ taken at BFC00010 -> delay slot BFC00014 -> BFC00020
    vecs[5]  = mk(1, 0, 1, 1, 0, 0, BEQ3,  32'h0,        32'hBFC00014, 1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00020, 1, 0);
    // BEQ not taken at BFC00020
    vecs[7]  = mk(1, 0, 1, 0, 0, 0, BEQ3,  32'h0,        32'hBFC00024, 1, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00028, 1, 0);
    // J in delay slot of J: second one ignored
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00000, 1, 0);
    vecs[10] = mk(1, 0, 0, 0, 1, 0, J_100, 32'h0,        32'hBFC00004, 1, 0);
    vecs[11] = mk(1, 0, 0, 0, 1, 0, J_200, 32'h0,        32'hBFC00100, 1, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00104, 1, 0);
    // misaligned JR, then halted, then reset clears it
    vecs[13] = mk(0, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00000, 1, 0);
    vecs[14] = mk(1, 0, 0, 0, 1, 1, NOP,   32'hBFC00102, 32'hBFC00004, 1, 1);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'h00000000, 0, 1);
    vecs[16] = mk(1, 0, 1, 1, 1, 0, J_100, 32'h0,        32'h00000000, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00000, 1, 0);
    // stall for 3 cycles in DELAY, then target
    vecs[18] = mk(1, 0, 1, 1, 0, 0, BEQ3,  32'h0,        32'hBFC00004, 1, 0);
    vecs[19] = mk(1, 1, 1, 1, 0, 0, BEQ3,  32'h0,        32'hBFC00004, 1, 0);
    vecs[20] = mk(1, 1, 0, 0, 1, 0, J_200, 32'h0,        32'hBFC00004, 1, 0);
    vecs[21] = mk(1, 1, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00004, 1, 0);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00010, 1, 0);
    // stall wins over a redirect in RUN; redirect re-evaluated next cycle
    vecs[23] = mk(1, 1, 0, 0, 1, 0, J_100, 32'h0,        32'hBFC00010, 1, 0);
    vecs[24] = mk(1, 0, 0, 0, 1, 0, J_100, 32'h0,        32'hBFC00014, 1, 0);
    vecs[25] = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00100, 1, 0);
    // reset (with stall) during DELAY discards pending target
    vecs[26] = mk(1, 0, 1, 1, 0, 0, BEQ3,  32'h0,        32'hBFC00104, 1, 0);
    vecs[27] = mk(0, 1, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00000, 1, 0);
    vecs[28] = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00004, 1, 0);
    // JR to 0 at BFC00008: delay slot BFC0000C, then halt
    vecs[29] = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'hBFC00008, 1, 0);
    vecs[30] = mk(1, 0, 0, 0, 1, 1, NOP,   32'h0,        32'hBFC0000C, 1, 0);
    vecs[31] = mk(1, 0, 0, 0, 0, 0, NOP,   32'h0,        32'h00000000, 0, 0);

    drive(vecs[0]);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check32($sformatf("pc[%0d]", i), instr_address, vecs[i].exp_pc);
      check32($sformatf("link[%0d]", i), link_addr, vecs[i].exp_pc + 32'd8);
      check1($sformatf("active[%0d]", i), active, vecs[i].exp_act);
      check1($sformatf("err[%0d]", i), addr_error, vecs[i].exp_err);
      check32($sformatf("instr[%0d]", i), instr, vecs[i].iw);
    end

    // Halted: PC pinned at 0 for 12 cycles whatever the inputs do.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      stall          = 1'($urandom_range(0, 1));
      branch         = 1'($urandom_range(0, 1));
      branch_cond    = 1'($urandom_range(0, 1));
      jump           = 1'($urandom_range(0, 1));
      jump1          = 1'($urandom_range(0, 1));
      reg_target     = $urandom;
      instr_readdata = $urandom;
      @(posedge clk);
      #1;
      check32($sformatf("halt_pc[%0d]", k), instr_address, 32'h0);
      check1($sformatf("halt_active[%0d]", k), active, 1'b0);
      check32($sformatf("halt_instr[%0d]", k), instr, instr_readdata);
    end

    // Recover by reset; instr follows memory combinationally under stall.
    @(negedge clk);
    reset_n = 1'b0; stall = 1'b0; jump = 1'b0; jump1 = 1'b0; branch = 1'b0;
    @(posedge clk);
    #1;
    check32("rst_pc", instr_address, 32'hBFC00000);
    check1("rst_active", active, 1'b1);
    @(negedge clk);
    reset_n = 1'b1; stall = 1'b1;
    instr_readdata = 32'hDEAD_BEEF;
    #1;
    check32("stall_instr_a", instr, 32'hDEAD_BEEF);
    instr_readdata = 32'h1234_5678;
    #1;
    check32("stall_instr_b", instr, 32'h1234_5678);
    @(posedge clk);
    #1;
    check32("stall_pc", instr_address, 32'hBFC00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
